// File: rtl/frv_alu_pipe_if.sv
// -----------------------------------------------------------------------------
// frv_alu_pipe_if
//   Bundles the operation-issue side and the result side of frv_alu_pipe.
//
//   Handshake rule (applies to both sides): a transfer happens on the rising
//   clock edge where valid && ready are both high. While valid is high and
//   ready is low, the producer holds valid and all payload signals stable.
//   alu_flush is not part of a handshake; it acts on the edge where it is high.
//
//   Signals
//     alu_flush     drop everything buffered plus the same-cycle input
//     alu_valid     operation valid
//     alu_ready     block can accept an operation (registered)
//     alu_op        operation code (see frv_alu_pipe)
//     alu_unsigned  unsigned variant for slt/min/max/sadd/ssub
//     alu_pw        lane width code, lane = 2^(alu_pw+1), clamped to XLEN
//     alu_lhs       left operand
//     alu_rhs       right operand
//     res_valid     result valid
//     res_ready     consumer accepts result
//     res_data      result word
//     res_eq        alu_lhs == alu_rhs for the operation behind res_data
//
//   Modports
//     master  the issuing execute stage plus the writeback consumer
//     slave   the ALU pipeline itself
// -----------------------------------------------------------------------------
interface frv_alu_pipe_if #(
  parameter int XLEN = 32
);
  logic            alu_flush;
  logic            alu_valid;
  logic            alu_ready;
  logic [3:0]      alu_op;
  logic            alu_unsigned;
  logic [2:0]      alu_pw;
  logic [XLEN-1:0] alu_lhs;
  logic [XLEN-1:0] alu_rhs;
  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] res_data;
  logic            res_eq;

  modport master (
    output alu_flush, alu_valid, alu_op, alu_unsigned, alu_pw, alu_lhs, alu_rhs,
    output res_ready,
    input  alu_ready, res_valid, res_data, res_eq
  );

  modport slave (
    input  alu_flush, alu_valid, alu_op, alu_unsigned, alu_pw, alu_lhs, alu_rhs,
    input  res_ready,
    output alu_ready, res_valid, res_data, res_eq
  );
endinterface

// File: rtl/frv_alu_pipe.sv
// -----------------------------------------------------------------------------
// frv_alu_pipe
//   Registered packed-SIMD integer ALU. One-cycle latency, full throughput,
//   with a two-entry output buffer (output register + skid register) so that
//   writeback back-pressure never reaches the execute stage combinationally.
//
//   Operations (alu_op):
//     0 add  1 sub  2 xor  3 or   4 and  5 sll  6 srl  7 sra
//     8 rol  9 ror 10 slt 11 min 12 max 13 pack 14 sadd 15 ssub
//   Lane width = 2^(alu_pw+1); codes that would reach or exceed XLEN give one
//   XLEN-wide lane. pack ignores alu_pw.
//
//   Configuration macro FRV_ALU_PIPE_SAT_EN:
//     defined   -> ops 14/15 saturate (signed, or unsigned when alu_unsigned)
//     undefined -> ops 14/15 are plain wrapping add/sub, no saturation logic
//
//   Ports
//     g_clk      rising-edge clock
//     g_resetn   asynchronous active-low reset
//     alu        frv_alu_pipe_if.slave (issue + result handshakes, flush)
//     dbg_state  output buffer state: 0 EMPTY, 1 FULL, 2 SKID
// -----------------------------------------------------------------------------
module frv_alu_pipe #(
  parameter int XLEN     = 32,
  parameter int LOG_XLEN = 5
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  frv_alu_pipe_if.slave alu,
  output logic [1:0]    dbg_state
);

  // ---------------------------------------------------------------------------
  // Operand aliases
  // ---------------------------------------------------------------------------
  logic [3:0]      op;
  logic            uns;
  logic [2:0]      pw;
  logic [XLEN-1:0] lhs;
  logic [XLEN-1:0] rhs;

  assign op  = alu.alu_op;
  assign uns = alu.alu_unsigned;
  assign pw  = alu.alu_pw;
  assign lhs = alu.alu_lhs;
  assign rhs = alu.alu_rhs;

  // ---------------------------------------------------------------------------
  // Lane datapath: one full-word result per supported lane width (2^k bits).
  // Each lane is an independent slice, so no carry or shift crosses a lane.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] lane_res [1:LOG_XLEN];

  for (genvar k = 1; k <= LOG_XLEN; k++) begin : g_width
    localparam int L = 2 ** k;
    logic [XLEN-1:0] w_res;

    for (genvar j = 0; j < XLEN / L; j++) begin : g_lane
      logic [L-1:0] a;
      logic [L-1:0] b;
      logic [L-1:0] r;
      logic [k-1:0] sh;
      logic [k:0]   rsh;   // L - sh, the complementary shift for rotates
      logic         lt;    // lhs lane < rhs lane
      logic         gt;    // lhs lane > rhs lane

      assign a   = lhs[j*L +: L];
      assign b   = rhs[j*L +: L];
      assign sh  = b[k-1:0];
      assign rsh = (k+1)'(L) - {1'b0, sh};
      assign lt  = uns ? (a < b) : ($signed(a) < $signed(b));
      assign gt  = uns ? (b < a) : ($signed(b) < $signed(a));

`ifdef FRV_ALU_PIPE_SAT_EN
      // One extra bit holds the carry/borrow (unsigned) or the true sign
      // (signed); disagreement with the lane MSB means overflow.
      logic [L:0]   s_ext;
      logic [L-1:0] sat_r;

      always_comb begin
        s_ext = '0;
        sat_r = '0;
        if (uns) begin
          s_ext = (op == 4'd14) ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} - {1'b0, b});
          if (s_ext[L]) sat_r = (op == 4'd14) ? {L{1'b1}} : {L{1'b0}};
          else          sat_r = s_ext[L-1:0];
        end else begin
          s_ext = (op == 4'd14) ? ({a[L-1], a} + {b[L-1], b}) : ({a[L-1], a} - {b[L-1], b});
          if (s_ext[L] != s_ext[L-1])
            sat_r = s_ext[L] ? {1'b1, {(L-1){1'b0}}} : {1'b0, {(L-1){1'b1}}};
          else
            sat_r = s_ext[L-1:0];
        end
      end
`endif

      always_comb begin
        r = '0;
        case (op)
          4'd0:  r = a + b;
          4'd1:  r = a - b;
          4'd2:  r = a ^ b;
          4'd3:  r = a | b;
          4'd4:  r = a & b;
          4'd5:  r = a << sh;
          4'd6:  r = a >> sh;
          4'd7:  r = $signed(a) >>> sh;
          // sh == 0 gives rsh == L, which shifts everything out -> plain copy.
          4'd8:  r = (a << sh) | (a >> rsh);
          4'd9:  r = (a >> sh) | (a << rsh);
          4'd10: r = {{(L-1){1'b0}}, lt};
          4'd11: r = gt ? b : a;  // ties keep lhs
          4'd12: r = lt ? b : a;  // ties keep lhs
`ifdef FRV_ALU_PIPE_SAT_EN
          4'd14: r = sat_r;
          4'd15: r = sat_r;
`else
          4'd14: r = a + b;
          4'd15: r = a - b;
`endif
          default: r = '0;        // pack is assembled at word level
        endcase
      end

      assign w_res[j*L +: L] = r;
    end

    assign lane_res[k] = w_res;
  end

  // Lane width select: codes at or beyond LOG_XLEN-1 fall to the full word.
  logic [XLEN-1:0] lane_sel;
  logic [XLEN-1:0] new_data;
  logic            new_eq;

  always_comb begin
    lane_sel = lane_res[LOG_XLEN];
    for (int k = 1; k < LOG_XLEN; k++) begin
      if (int'(pw) + 1 == k) lane_sel = lane_res[k];
    end
  end

  assign new_data = (op == 4'd13) ? {rhs[XLEN/2-1:0], lhs[XLEN/2-1:0]} : lane_sel;
  assign new_eq   = (lhs == rhs);

  // ---------------------------------------------------------------------------
  // Output buffer FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } buf_state_t;

  buf_state_t state_q;
  buf_state_t state_d;
  logic       ready_q;
  logic       accept;
  logic       consume;
  logic       load_out;
  logic       load_skid;
  logic       move_skid;

  logic [XLEN-1:0] out_data_q;
  logic            out_eq_q;
  logic [XLEN-1:0] skid_data_q;
  logic            skid_eq_q;

  assign accept  = alu.alu_valid && ready_q;
  assign consume = (state_q != ST_EMPTY) && alu.res_ready;

  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (alu.alu_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d  = ST_FULL;
            load_out = 1'b1;
          end
        end
        ST_FULL: begin
          if (accept && consume) begin
            load_out = 1'b1;
          end else if (accept) begin
            state_d   = ST_SKID;
            load_skid = 1'b1;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (consume) begin
            state_d   = ST_FULL;
            move_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // ready is computed from the next state and registered, so res_ready has
  // no combinational path to alu_ready.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_SKID);
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      out_data_q  <= '0;
      out_eq_q    <= 1'b0;
      skid_data_q <= '0;
      skid_eq_q   <= 1'b0;
    end else begin
      if (load_out) begin
        out_data_q <= new_data;
        out_eq_q   <= new_eq;
      end else if (move_skid) begin
        out_data_q <= skid_data_q;
        out_eq_q   <= skid_eq_q;
      end
      if (load_skid) begin
        skid_data_q <= new_data;
        skid_eq_q   <= new_eq;
      end
    end
  end

  assign alu.alu_ready = ready_q;
  assign alu.res_valid = (state_q != ST_EMPTY);
  assign alu.res_data  = out_data_q;
  assign alu.res_eq    = out_eq_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_frv_alu_pipe.sv
module tb_frv_alu_pipe;

  localparam int XLEN     = 32;
  localparam int LOG_XLEN = 5;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_SKID  = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_XOR = 4'd2,  OP_AND = 4'd4;
  localparam logic [3:0] OP_SRA = 4'd7,  OP_ROL = 4'd8,  OP_ROR = 4'd9,  OP_SLT = 4'd10;
  localparam logic [3:0] OP_MIN = 4'd11, OP_MAX = 4'd12, OP_PACK = 4'd13;
  localparam logic [3:0] OP_SADD = 4'd14, OP_SSUB = 4'd15;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       g_clk    = 1'b0;
  logic       g_resetn = 1'b0;
  logic [1:0] dbg_state;

  always #5 g_clk = ~g_clk;

  frv_alu_pipe_if #(.XLEN(XLEN)) bus ();

  frv_alu_pipe #(
    .XLEN     (XLEN),
    .LOG_XLEN (LOG_XLEN)
  ) dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .alu       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int              total = 0;
  int              bad   = 0;
  logic [XLEN:0]   exp_q[$];   // {eq, data}
  logic [XLEN:0]   mon_e;
  bit              rand_rr = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge g_clk) begin
    if (g_resetn && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_res", {63'd0, bus.res_valid}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_data", {32'd0, bus.res_data}, {32'd0, mon_e[XLEN-1:0]});
        check("res_eq", {63'd0, bus.res_eq}, {63'd0, mon_e[XLEN]});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model (integer arithmetic per lane)
  // ---------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] model(input logic [3:0] op, input logic uns,
                                            input logic [2:0] pw,
                                            input logic [XLEN-1:0] lhs,
                                            input logic [XLEN-1:0] rhs);
    int              L;
    longint          mask, a, b, sa, sb, ca, cb, sh, r, lo, hi, tmp;
    logic [XLEN-1:0] res;
    if (op == OP_PACK) return {rhs[XLEN/2-1:0], lhs[XLEN/2-1:0]};
    L    = (int'(pw) >= LOG_XLEN) ? XLEN : (2 << int'(pw));
    mask = (longint'(1) << L) - 1;
    res  = '0;
    for (int j = 0; j < XLEN / L; j++) begin
      a  = (longint'(lhs) >> (j * L)) & mask;
      b  = (longint'(rhs) >> (j * L)) & mask;
      sa = (a >= (longint'(1) << (L - 1))) ? a - (longint'(1) << L) : a;
      sb = (b >= (longint'(1) << (L - 1))) ? b - (longint'(1) << L) : b;
      ca = uns ? a : sa;
      cb = uns ? b : sb;
      sh = b & (L - 1);
      case (op)
        4'd0:  r = a + b;
        4'd1:  r = a - b;
        4'd2:  r = a ^ b;
        4'd3:  r = a | b;
        4'd4:  r = a & b;
        4'd5:  r = a << sh;
        4'd6:  r = a >> sh;
        4'd7:  r = sa >>> sh;
        4'd8:  r = (a << sh) | (a >> (L - sh));
        4'd9:  r = (a >> sh) | (a << (L - sh));
        4'd10: r = (ca < cb) ? 1 : 0;
        4'd11: r = (cb < ca) ? b : a;
        4'd12: r = (ca < cb) ? b : a;
        default: begin
`ifdef FRV_ALU_PIPE_SAT_EN
          r  = (op == OP_SADD) ? ca + cb : ca - cb;
          lo = uns ? 0 : -(longint'(1) << (L - 1));
          hi = uns ? mask : (longint'(1) << (L - 1)) - 1;
          if (r < lo) r = lo;
          if (r > hi) r = hi;
`else
          r = (op == OP_SADD) ? a + b : a - b;
`endif
        end
      endcase
      tmp = (r & mask) << (j * L);
      res = res | tmp[XLEN-1:0];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic send(input logic [3:0] op, input logic uns, input logic [2:0] pw,
                      input logic [XLEN-1:0] lhs, input logic [XLEN-1:0] rhs,
                      input logic [XLEN-1:0] exp_data);
    bit acc;
    int n;
    bus.alu_valid    = 1'b1;
    bus.alu_op       = op;
    bus.alu_unsigned = uns;
    bus.alu_pw       = pw;
    bus.alu_lhs      = lhs;
    bus.alu_rhs      = rhs;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge g_clk);
      acc = bus.alu_ready;
      @(posedge g_clk);
      #1;
      if (rand_rr) bus.res_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    bus.alu_valid = 1'b0;
    if (acc) exp_q.push_back({lhs == rhs, exp_data});
    else     check("accept_timeout", {63'd0, acc}, 64'd1);
  endtask

  // Send with res_ready high and confirm the result is visible one cycle later.
  task automatic send_lat(input string tag, input logic [3:0] op, input logic uns,
                          input logic [2:0] pw, input logic [XLEN-1:0] lhs,
                          input logic [XLEN-1:0] rhs, input logic [XLEN-1:0] exp_data);
    send(op, uns, pw, lhs, rhs, exp_data);
    @(negedge g_clk);
    check({tag, "_valid"}, {63'd0, bus.res_valid}, 64'd1);
    check(tag, {32'd0, bus.res_data}, {32'd0, exp_data});
    @(posedge g_clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge g_clk);
      n++;
    end
    #1;
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [3:0]      r_op;
    logic            r_uns;
    logic [2:0]      r_pw;
    logic [XLEN-1:0] r_lhs, r_rhs;

    bus.alu_flush    = 1'b0;
    bus.alu_valid    = 1'b0;
    bus.alu_op       = '0;
    bus.alu_unsigned = 1'b0;
    bus.alu_pw       = '0;
    bus.alu_lhs      = '0;
    bus.alu_rhs      = '0;
    bus.res_ready    = 1'b1;

    // Reset state
    #3;
    check("rst_valid", {63'd0, bus.res_valid}, 64'd0);
    check("rst_data", {32'd0, bus.res_data}, 64'd0);
    check("rst_eq", {63'd0, bus.res_eq}, 64'd0);
    repeat (2) @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    @(negedge g_clk);
    check("rst_ready", {63'd0, bus.alu_ready}, 64'd1);
    check("rst_state", {62'd0, dbg_state}, {62'd0, S_EMPTY});
    @(posedge g_clk);
    #1;

    // Directed function checks
    send_lat("add16", OP_ADD, 1'b0, 3'd3, 32'h0001_FFFF, 32'h0001_0001, 32'h0002_0000);
    send_lat("sra8", OP_SRA, 1'b0, 3'd2, 32'h80F0_7F01, 32'h0101_0101, 32'hC0F8_3F00);
    send_lat("ror32", OP_ROR, 1'b0, 3'd4, 32'h0000_0001, 32'h0000_0001, 32'h8000_0000);
    send_lat("min8s", OP_MIN, 1'b0, 3'd2, 32'h7F80_0102, 32'h8001_0201, 32'h8080_0101);
    send_lat("min8u", OP_MIN, 1'b1, 3'd2, 32'h7F80_0102, 32'h8001_0201, 32'h7F01_0101);
    send_lat("rol2", OP_ROL, 1'b0, 3'd0, 32'h0000_0001, 32'h0000_0003, 32'h0000_0002);
    send_lat("slt16", OP_SLT, 1'b0, 3'd3, 32'h8000_0001, 32'h0001_0001, 32'h0001_0000);
    send_lat("max8tie", OP_MAX, 1'b1, 3'd2, 32'h8001_0203, 32'h8002_0103, 32'h8002_0203);
    send_lat("pack", OP_PACK, 1'b0, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'hDEF0_5678);
    send_lat("add_pw7", OP_ADD, 1'b0, 3'd7, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000);
    send_lat("xor_eq", OP_XOR, 1'b0, 3'd2, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000);
`ifdef FRV_ALU_PIPE_SAT_EN
    send_lat("sadd8s", OP_SADD, 1'b0, 3'd2, 32'h7F80_0000, 32'h0180_0000, 32'h7F80_0000);
    send_lat("ssub8u", OP_SSUB, 1'b1, 3'd2, 32'h0000_0005, 32'h0000_0009, 32'h0000_0000);
`else
    send_lat("sadd8s", OP_SADD, 1'b0, 3'd2, 32'h7F80_0000, 32'h0180_0000, 32'h8000_0000);
    send_lat("ssub8u", OP_SSUB, 1'b1, 3'd2, 32'h0000_0005, 32'h0000_0009, 32'h0000_00FC);
`endif
    drain();

    // Back-pressure: A in output reg, B in skid, C held off
    bus.res_ready = 1'b0;
    send(OP_ADD, 1'b0, 3'd4, 32'd1, 32'd1, 32'd2);
    send(OP_ADD, 1'b0, 3'd4, 32'd10, 32'd10, 32'd20);
    fork
      send(OP_SUB, 1'b0, 3'd4, 32'd40, 32'd10, 32'd30);
      begin
        @(negedge g_clk);
        check("bp_ready", {63'd0, bus.alu_ready}, 64'd0);
        check("bp_valid", {63'd0, bus.res_valid}, 64'd1);
        check("bp_data", {32'd0, bus.res_data}, 64'd2);
        check("bp_state", {62'd0, dbg_state}, {62'd0, S_SKID});
        @(negedge g_clk);
        check("bp_hold_data", {32'd0, bus.res_data}, 64'd2);
        check("bp_hold_ready", {63'd0, bus.alu_ready}, 64'd0);
        @(posedge g_clk);
        #1;
        bus.res_ready = 1'b1;
      end
    join
    drain();

    // Flush while in SKID with a valid input
    bus.res_ready = 1'b0;
    send(OP_ADD, 1'b0, 3'd4, 32'd3, 32'd4, 32'd7);
    send(OP_ADD, 1'b0, 3'd4, 32'd5, 32'd6, 32'd11);
    check("fl_pre_state", {62'd0, dbg_state}, {62'd0, S_SKID});
    bus.alu_flush = 1'b1;
    bus.alu_valid = 1'b1;
    bus.alu_op    = OP_ADD;
    bus.alu_lhs   = 32'h111;
    bus.alu_rhs   = 32'h222;
    @(posedge g_clk);
    #1;
    bus.alu_flush = 1'b0;
    bus.alu_valid = 1'b0;
    exp_q.delete();
    @(negedge g_clk);
    check("fl_valid", {63'd0, bus.res_valid}, 64'd0);
    check("fl_ready", {63'd0, bus.alu_ready}, 64'd1);
    check("fl_state", {62'd0, dbg_state}, {62'd0, S_EMPTY});

    // Flush while FULL: the same-cycle input is accepted-then-dropped
    @(posedge g_clk);
    #1;
    send(OP_ADD, 1'b0, 3'd4, 32'd8, 32'd9, 32'd17);
    bus.alu_flush = 1'b1;
    bus.alu_valid = 1'b1;
    bus.alu_lhs   = 32'h333;
    bus.alu_rhs   = 32'h444;
    @(posedge g_clk);
    #1;
    bus.alu_flush = 1'b0;
    bus.alu_valid = 1'b0;
    exp_q.delete();
    bus.res_ready = 1'b1;
    repeat (4) begin
      @(negedge g_clk);
      check("fl_quiet", {63'd0, bus.res_valid}, 64'd0);
    end
    @(posedge g_clk);
    #1;

    // Asynchronous reset mid-stream
    bus.res_ready = 1'b0;
    send(OP_AND, 1'b0, 3'd4, 32'h0000_5A5A, 32'h0000_5A5A, 32'h0000_5A5A);
    #2;
    g_resetn = 1'b0;
    #1;
    check("arst_valid", {63'd0, bus.res_valid}, 64'd0);
    check("arst_data", {32'd0, bus.res_data}, 64'd0);
    check("arst_eq", {63'd0, bus.res_eq}, 64'd0);
    exp_q.delete();
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    @(negedge g_clk);
    check("arst_ready", {63'd0, bus.alu_ready}, 64'd1);
    @(posedge g_clk);
    #1;
    bus.res_ready = 1'b1;

    // Random traffic with random back-pressure
    rand_rr = 1'b1;
    for (int i = 0; i < 120; i++) begin
      r_op  = 4'($urandom_range(0, 15));
      r_uns = 1'($urandom_range(0, 1));
      r_pw  = 3'($urandom_range(0, 7));
      r_lhs = $urandom();
      r_rhs = ($urandom_range(0, 9) == 0) ? r_lhs : $urandom();
      send(r_op, r_uns, r_pw, r_lhs, r_rhs, model(r_op, r_uns, r_pw, r_lhs, r_rhs));
    end
    rand_rr       = 1'b0;
    bus.res_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
